// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Decides each cycle whether the decode instruction issues into ALU/EX1, or
//   whether fetch/decode stall while a bubble enters ALU/EX1. A per-register
//   countdown (cnt) tracks how many more cycles a pending ALU/LOAD/MUL result
//   needs before it can be bypassed. A shift register (resv) tracks future
//   write-back port occupancy by the longer MUL path.
//
// Ports:
//   clk_i            in   clock
//   rst_i            in   synchronous active-high reset
//   dec_valid_i      in   valid instruction in decode
//   hazard_signals_i in   rs1, rs2, rs1_needed, rs2_needed, is_mul
//   instr_is_wb_i    in   decode instruction writes a GPR
//   is_load_i        in   decode instruction is a LOAD
//   wr_reg_i         in   decode destination register
//   mem_stall_i      in   D-side stall, freezes ALU/MEM/WB and EX1..EX5
//   flush_i          in   kill the decode instruction this cycle
//   issue_o          out  decode instruction advances to ALU/EX1
//   stall_fd_o       out  hold fetch and decode registers
//   bubble_o         out  clear ALU/EX1 valid next cycle
//   stall_raw_cnt_o  out  RAW stall cycle counter        (HAZARD_PERF_CNT_EN)
//   stall_wb_cnt_o   out  WB-conflict stall cycle counter (HAZARD_PERF_CNT_EN)
//
// Build option:
//   HAZARD_PERF_CNT_EN - when defined, adds the two stall performance counters
//   and their ports; when undefined they are absent.
// -----------------------------------------------------------------------------

package params_pkg;
  localparam int unsigned REGISTER_WIDTH = 5;

  typedef struct packed {
    logic [REGISTER_WIDTH-1:0] rs1;
    logic [REGISTER_WIDTH-1:0] rs2;
    logic                      rs1_needed;
    logic                      rs2_needed;
    logic                      is_mul;
  } hazard_ctrl_t;
endpackage

module hazard_scoreboard #(
  // Must match params_pkg::REGISTER_WIDTH, which sizes the hazard bundle.
  parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned MUL_LAT        = 4,
  parameter int unsigned ALU_WB_DIST    = 3,
  parameter int unsigned MUL_WB_DIST    = 6
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned PERF_CNT_WIDTH = 32
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        dec_valid_i,
  input  params_pkg::hazard_ctrl_t    hazard_signals_i,
  input  logic                        instr_is_wb_i,
  input  logic                        is_load_i,
  input  logic [REGISTER_WIDTH-1:0]   wr_reg_i,
  input  logic                        mem_stall_i,
  input  logic                        flush_i,
  output logic                        issue_o,
  output logic                        stall_fd_o,
  output logic                        bubble_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0]   stall_raw_cnt_o,
  output logic [PERF_CNT_WIDTH-1:0]   stall_wb_cnt_o
`endif
);

  localparam int unsigned NUM_REGS = 1 << REGISTER_WIDTH;

  // One bit per register: result still in flight (cnt != 0).
  logic [NUM_REGS-1:0]    busy_vec;
  logic [MUL_WB_DIST-1:0] resv_q;
  logic [MUL_WB_DIST-1:0] resv_d;

  logic       rs1_busy;
  logic       rs2_busy;
  logic       raw_stall;
  logic       wb_stall;
  logic       live;       // valid and not flushed
  logic       wr_en;
  logic [2:0] wr_lat;

  // ---------------------------------------------------------------------------
  // Stall decision
  // ---------------------------------------------------------------------------
  // x0 is hardwired zero, so reading it never waits on anything.
  assign rs1_busy = hazard_signals_i.rs1_needed && (hazard_signals_i.rs1 != '0) &&
                    busy_vec[hazard_signals_i.rs1];
  assign rs2_busy = hazard_signals_i.rs2_needed && (hazard_signals_i.rs2 != '0) &&
                    busy_vec[hazard_signals_i.rs2];
  assign raw_stall = rs1_busy || rs2_busy;

  // A short-path writer would reach WB in the same cycle as an older MUL.
  // MULs never collide with each other since at most one issues per cycle.
  assign wb_stall = instr_is_wb_i && !hazard_signals_i.is_mul && resv_q[ALU_WB_DIST-1];

  assign live       = dec_valid_i && !flush_i;
  assign issue_o    = live && !mem_stall_i && !raw_stall && !wb_stall;
  assign stall_fd_o = live && (mem_stall_i || raw_stall || wb_stall);
  // The frozen pipe never takes a bubble.
  assign bubble_o   = !issue_o && !mem_stall_i;

  // ---------------------------------------------------------------------------
  // Readiness scoreboard
  // ---------------------------------------------------------------------------
  assign wr_en = issue_o && instr_is_wb_i && (wr_reg_i != '0);

  always_comb begin
    wr_lat = 3'd0;
    if (is_load_i) begin
      wr_lat = 3'(LOAD_LAT);
    end else if (hazard_signals_i.is_mul) begin
      wr_lat = 3'(MUL_LAT);
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (!mem_stall_i) begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end
        // A new writer replaces whatever was pending on this register.
        if (wr_en && (wr_reg_i == REGISTER_WIDTH'(gi))) begin
          cnt_d = wr_lat;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= 3'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy_vec[gi] = (cnt_q != 3'd0);
  end

  // ---------------------------------------------------------------------------
  // Write-back port reservations: bit k set = WB taken k+1 cycles from now.
  // ---------------------------------------------------------------------------
  always_comb begin
    resv_d = resv_q;
    if (!mem_stall_i) begin
      resv_d = resv_q >> 1;
      // A MUL issuing now writes back MUL_WB_DIST cycles later; after this
      // edge that is MUL_WB_DIST-1 cycles away, i.e. bit MUL_WB_DIST-2.
      resv_d[MUL_WB_DIST-2] = resv_d[MUL_WB_DIST-2] | (issue_o & hazard_signals_i.is_mul);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resv_q <= '0;
    end else begin
      resv_q <= resv_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall performance counters (wrap naturally). RAW takes precedence so a
  // cycle with both causes is counted once.
  // ---------------------------------------------------------------------------
  logic [PERF_CNT_WIDTH-1:0] raw_cnt_q;
  logic [PERF_CNT_WIDTH-1:0] wb_cnt_q;
  logic                      cnt_qual;

  assign cnt_qual = live && !mem_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      if (cnt_qual && raw_stall) begin
        raw_cnt_q <= raw_cnt_q + 1'b1;
      end
      if (cnt_qual && !raw_stall && wb_stall) begin
        wb_cnt_q <= wb_cnt_q + 1'b1;
      end
    end
  end

  assign stall_raw_cnt_o = raw_cnt_q;
  assign stall_wb_cnt_o  = wb_cnt_q;
`endif

endmodule
